// File: rtl/tdc_delayline_ctrl_pkg.sv
// Shared definitions for the tapped-delay-line TDC controller.
//   state_t       : controller FSM state encodings
//   DEF_TAPS      : default number of delay-line taps (4 CARRY4 stages x 4)
//   DEF_COARSE_W  : default coarse counter width
//   CNT_W         : width of the internal dead/calibration counters
//   fine_width()  : fine-code width needed to hold a popcount of 0..taps
package tdc_delayline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_CAL    = 3'd2,
        ST_ENCODE = 3'd3,
        ST_OUT    = 3'd4,
        ST_DEAD   = 3'd5
    } state_t;

    localparam int DEF_TAPS     = 16;
    localparam int DEF_COARSE_W = 16;
    localparam int CNT_W        = 16;

    function automatic int fine_width(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/tdc_delayline_ctrl_therm_popcount.sv
// Combinational thermometer-code encoder for the delay line.
// Counting set taps rather than locating the 1->0 transition makes the
// result tolerant of bubbles in the thermometer code. Also used by the
// calibration histogrammer.
//   therm : latched tap vector, therm[0] is the first tap
//   count : number of taps set (fine code)
module tdc_delayline_ctrl_therm_popcount
    import tdc_delayline_ctrl_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int FINE_W = fine_width(DEF_TAPS)
) (
    input  logic [TAPS-1:0]   therm,
    output logic [FINE_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < TAPS; i++) begin
            count = count + FINE_W'(therm[i]);
        end
    end

endmodule

// File: rtl/tdc_delayline_ctrl.sv
// Measurement controller for the CARRY4 tapped delay line TDC.
// Detects a hit on the first tap, latches the coarse count and taps,
// encodes the fine value and presents {coarse, fine} over valid/ready.
// Also drives calibration pulses into the line CI and enforces dead time.
//   clk, rst_n : system clock, asynchronous active-low reset
//   enable     : run control, low forces IDLE
//   cal_req    : single-cycle request for one calibration shot
//   taps       : double-registered delay-line outputs
//   cal_sel    : CI mux select (1 = line_ci drives the line)
//   line_ci    : calibration pulse into the CI input
//   ts_data    : {coarse, fine} timestamp
//   ts_cal     : timestamp came from a calibration shot
//   ts_valid   : timestamp available, ts_ready accepts it
//   busy       : controller is neither ARMED nor IDLE
//   cal_err    : one-cycle pulse when a calibration edge never arrived
//   drop_cnt   : hits lost while not armed, saturating at 255
module tdc_delayline_ctrl
    import tdc_delayline_ctrl_pkg::*;
#(
    parameter int TAPS        = DEF_TAPS,
    parameter int COARSE_W    = DEF_COARSE_W,
    parameter int DEAD_CYCLES = 4,
    parameter int CAL_WIDTH   = 8,
    parameter int CAL_TIMEOUT = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic                                cal_req,
    input  logic [TAPS-1:0]                     taps,
    output logic                                cal_sel,
    output logic                                line_ci,
    output logic [COARSE_W+$clog2(TAPS+1)-1:0]  ts_data,
    output logic                                ts_cal,
    output logic                                ts_valid,
    input  logic                                ts_ready,
    output logic                                busy,
    output logic                                cal_err,
    output logic [7:0]                          drop_cnt
);

    localparam int FINE_W = fine_width(TAPS);

    state_t               state;
    state_t               state_nx;
    logic                 tap0_p1;
    logic                 hit;
    logic                 taps_zero;
    logic                 cal_go;
    logic                 cal_timeout;
    logic                 dead_done;
    logic                 drop_state;
    logic [COARSE_W-1:0]  coarse;
    logic [COARSE_W-1:0]  coarse_lat;
    logic [TAPS-1:0]      taps_lat;
    logic                 cal_lat;
    logic [FINE_W-1:0]    fine;
    logic [CNT_W-1:0]     cal_cnt;
    logic [CNT_W-1:0]     dead_cnt;
    logic [CNT_W-1:0]     ci_cnt;
    logic                 cal_pend;
    logic                 cal_mode;

    assign hit         = taps[0] & ~tap0_p1;
    assign taps_zero   = (taps == '0);
    assign cal_go      = cal_req | cal_pend;
    assign cal_timeout = (cal_cnt == CNT_W'(CAL_TIMEOUT - 1));
    assign dead_done   = (dead_cnt >= CNT_W'(DEAD_CYCLES - 1));
    assign drop_state  = (state == ST_ENCODE) || (state == ST_OUT) || (state == ST_DEAD);

    tdc_delayline_ctrl_therm_popcount #(
        .TAPS   (TAPS),
        .FINE_W (FINE_W)
    ) u_popcount (
        .therm (taps_lat),
        .count (fine)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (taps_zero) state_nx = ST_ARMED;
                ST_ARMED: begin
                    if (hit)         state_nx = ST_ENCODE;
                    else if (cal_go) state_nx = ST_CAL;
                end
                ST_CAL: begin
                    if (hit)              state_nx = ST_ENCODE;
                    else if (cal_timeout) state_nx = ST_DEAD;
                end
                ST_ENCODE: state_nx = ST_OUT;
                ST_OUT:    if (ts_valid && ts_ready) state_nx = ST_DEAD;
                ST_DEAD:   if (dead_done && taps_zero) state_nx = ST_ARMED;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state and control registers
    always_comb begin
        busy    = (state != ST_ARMED) && (state != ST_IDLE);
        cal_sel = cal_mode;
        line_ci = (ci_cnt != '0);
    end

    // Control registers, coarse counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap0_p1  <= 1'b0;
            coarse   <= '0;
            cal_pend <= 1'b0;
            cal_mode <= 1'b0;
            cal_cnt  <= '0;
            dead_cnt <= '0;
            ci_cnt   <= '0;
            cal_err  <= 1'b0;
            drop_cnt <= '0;
            ts_valid <= 1'b0;
            ts_data  <= '0;
            ts_cal   <= 1'b0;
        end else begin
            tap0_p1 <= taps[0];
            coarse  <= enable ? coarse + COARSE_W'(1) : '0;

            // A request that is not consumed right now (hit wins, or not
            // armed) is remembered and served on the next ARMED cycle.
            if (state == ST_ARMED && state_nx == ST_CAL) begin
                cal_pend <= 1'b0;
            end else if (cal_req) begin
                cal_pend <= 1'b1;
            end

            // cal_sel stays up through ENCODE/OUT/DEAD of a calibration
            // shot so external hits cannot enter while the line drains.
            if (state_nx == ST_CAL) begin
                cal_mode <= 1'b1;
            end else if (state_nx == ST_ARMED || state_nx == ST_IDLE) begin
                cal_mode <= 1'b0;
            end

            // The CI pulse width is independent of how soon the edge
            // arrives, so it runs on its own down-counter.
            if (state_nx == ST_ARMED || state_nx == ST_IDLE) begin
                ci_cnt <= '0;
            end else if (state == ST_ARMED && state_nx == ST_CAL) begin
                ci_cnt <= CNT_W'(CAL_WIDTH);
            end else if (ci_cnt != '0) begin
                ci_cnt <= ci_cnt - CNT_W'(1);
            end

            cal_cnt <= (state == ST_CAL) ? cal_cnt + CNT_W'(1) : '0;

            if (state == ST_DEAD) begin
                if (!dead_done) dead_cnt <= dead_cnt + CNT_W'(1);
            end else begin
                dead_cnt <= '0;
            end

            cal_err <= (state == ST_CAL) && (state_nx == ST_DEAD);

            if (hit && drop_state && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end

            if (!enable) begin
                ts_valid <= 1'b0;
            end else if (state == ST_ENCODE) begin
                ts_valid <= 1'b1;
                ts_data  <= {coarse_lat, fine};
                ts_cal   <= cal_lat;
            end else if (ts_valid && ts_ready) begin
                ts_valid <= 1'b0;
            end
        end
    end

    // Hit capture: coarse and taps of the edge cycle feed ENCODE
    always_ff @(posedge clk) begin
        if (hit && (state == ST_ARMED || state == ST_CAL)) begin
            coarse_lat <= coarse;
            taps_lat   <= taps;
            cal_lat    <= (state == ST_CAL);
        end
    end

endmodule

// File: tb/tb_tdc_delayline_ctrl.sv
module tb_tdc_delayline_ctrl;

    localparam int TAPS     = 16;
    localparam int COARSE_W = 16;
    localparam int FINE_W   = 5;
    localparam int TS_W     = COARSE_W + FINE_W;

    typedef struct packed {
        logic            cal;
        logic [TS_W-1:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                cal_req = 1'b0;
    logic                ts_ready = 1'b0;
    logic [TAPS-1:0]     taps;
    logic [TAPS-1:0]     taps_drv = '0;
    logic                cal_sel, line_ci, ts_cal, ts_valid, busy, cal_err;
    logic [TS_W-1:0]     ts_data;
    logic [7:0]          drop_cnt;

    logic                line_en = 1'b0;
    logic                ci_d1 = 1'b0, ci_d2 = 1'b0, ci_d2_q = 1'b0;
    logic [COARSE_W-1:0] mdl_coarse;
    exp_t                exp_q[$];
    exp_t                mon_e;
    exp_t                last_pop;
    int                  n_cmp = 0, n_bad = 0, n_pop = 0, exp_drop = 0;

    tdc_delayline_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .cal_req  (cal_req),
        .taps     (taps),
        .cal_sel  (cal_sel),
        .line_ci  (line_ci),
        .ts_data  (ts_data),
        .ts_cal   (ts_cal),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .busy     (busy),
        .cal_err  (cal_err),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Line model: CI echoes into every tap after two register stages
    assign taps = taps_drv | {TAPS{line_en & ci_d2}};
    always @(posedge clk) begin
        ci_d1 <= line_ci;
        ci_d2 <= ci_d1;
    end

    // Reference coarse counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mdl_coarse <= '0;
        else if (enable) mdl_coarse <= mdl_coarse + 16'd1;
        else             mdl_coarse <= '0;
    end

    // A rising line edge is a calibration hit: expect all taps set
    always @(negedge clk) begin
        if (line_en && ci_d2 && !ci_d2_q)
            exp_q.push_back({1'b1, mdl_coarse, 5'd16});
        ci_d2_q <= ci_d2;
    end

    // Scoreboard: compare every accepted timestamp
    always @(negedge clk) begin
        if (rst_n && ts_valid && ts_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL ts_unexpected: got cal=%0b data=%h, required no transfer", ts_cal, ts_data);
            end else begin
                mon_e = exp_q.pop_front();
                n_pop++;
                last_pop = {ts_cal, ts_data};
                if ({ts_cal, ts_data} !== mon_e) begin
                    n_bad++;
                    $display("FAIL ts_data: got cal=%0b data=%h, required cal=%0b data=%h",
                             ts_cal, ts_data, mon_e.cal, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_armed(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            @(negedge clk);
            k++;
        end while (busy !== 1'b0 && k < 300);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_rearm: got busy=%0b after %0d cycles, required 0", tag, busy, k);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({cal_sel, line_ci, ts_cal, ts_valid, busy, cal_err, drop_cnt, ts_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {cal_sel, line_ci, ts_cal, ts_valid, busy, cal_err, drop_cnt, ts_data});
        end
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_armed("reset");
    endtask

    task automatic test_hit_basic();
        int k;
        ts_ready = 1'b1;
        k = 0;
        do begin tick(); k++; end while (mdl_coarse != 16'h0123 && k < 1000);
        taps_drv = 16'h00FF;
        exp_q.push_back({1'b0, 16'h0123, 5'd8});
        @(negedge clk);
        n_cmp++;
        if (ts_valid !== 1'b0) begin n_bad++; $display("FAIL hit_valid_n0: got %0b, required 0", ts_valid); end
        tick(); @(negedge clk);
        n_cmp++;
        if (ts_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL hit_encode: got valid=%0b busy=%0b, required 0/1", ts_valid, busy);
        end
        tick(); @(negedge clk);
        n_cmp++;
        if (ts_valid !== 1'b1) begin n_bad++; $display("FAIL hit_valid_n2: got %0b, required 1", ts_valid); end
        tick(); tick();
        taps_drv = '0;
        wait_armed("hit");
        n_cmp++;
        if (n_pop !== 1 || ts_valid !== 1'b0) begin
            n_bad++; $display("FAIL hit_count: got pops=%0d valid=%0b, required 1/0", n_pop, ts_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        ts_ready = 1'b0;
        tick();
        taps_drv = 16'h000F;
        e = {1'b0, mdl_coarse, 5'd4};
        exp_q.push_back(e);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) taps_drv = '0;
            if (i == 4) taps_drv = 16'h0001;
            @(negedge clk);
            if (i >= 2) begin
                n_cmp++;
                if (ts_valid !== 1'b1 || {ts_cal, ts_data} !== e) begin
                    n_bad++;
                    $display("FAIL bp_hold: cycle %0d got valid=%0b data=%h, required 1/%h",
                             i, ts_valid, {ts_cal, ts_data}, e);
                end
            end
            if (i == 5) exp_drop = 1;
            if (i == 4 || i == 5) begin
                n_cmp++;
                if (drop_cnt !== 8'(exp_drop)) begin
                    n_bad++; $display("FAIL bp_drop: cycle %0d got %0d, required %0d", i, drop_cnt, exp_drop);
                end
            end
        end
        tick();
        ts_ready = 1'b1;
        taps_drv = '0;
        wait_armed("bp");
        n_cmp++;
        if (n_pop !== 2) begin n_bad++; $display("FAIL bp_pops: got %0d, required 2", n_pop); end
    endtask

    task automatic test_cal_shot();
        int ci_n;
        line_en  = 1'b1;
        ts_ready = 1'b1;
        tick();
        cal_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cal_sel !== 1'b0) begin n_bad++; $display("FAIL cal_sel_early: got %0b, required 0", cal_sel); end
        tick();
        cal_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cal_sel !== 1'b1 || line_ci !== 1'b1) begin
            n_bad++; $display("FAIL cal_entry: got sel=%0b ci=%0b, required 1/1", cal_sel, line_ci);
        end
        ci_n = line_ci ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick(); @(negedge clk);
            if (line_ci === 1'b1) ci_n++;
        end
        n_cmp++;
        if (ci_n !== 8) begin n_bad++; $display("FAIL cal_ci_width: got %0d cycles, required 8", ci_n); end
        wait_armed("cal");
        n_cmp++;
        if (cal_sel !== 1'b0 || line_ci !== 1'b0 || n_pop !== 3) begin
            n_bad++; $display("FAIL cal_done: got sel=%0b ci=%0b pops=%0d, required 0/0/3", cal_sel, line_ci, n_pop);
        end
        line_en = 1'b0;
    endtask

    task automatic test_cal_timeout();
        int pulses, at;
        logic any_valid;
        pulses = 0; at = -1; any_valid = 1'b0;
        tick();
        cal_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            if (i == 1) cal_req = 1'b0;
            @(negedge clk);
            if (cal_err === 1'b1) begin pulses++; at = i; end
            if (ts_valid !== 1'b0) any_valid = 1'b1;
        end
        n_cmp++;
        if (pulses !== 1 || at !== 9) begin
            n_bad++; $display("FAIL cal_err_pulse: got %0d pulses at cycle %0d, required 1 at 9", pulses, at);
        end
        n_cmp++;
        if (any_valid !== 1'b0 || n_pop !== 3) begin
            n_bad++; $display("FAIL cal_timeout_ts: got valid_seen=%0b pops=%0d, required 0/3", any_valid, n_pop);
        end
        wait_armed("timeout");
    endtask

    task automatic test_back_to_back_wrap();
        int k;
        line_en  = 1'b1;
        ts_ready = 1'b1;
        k = 0;
        do begin tick(); k++; end while (mdl_coarse != 16'hFFFF && k < 70000);
        taps_drv = 16'h0007;
        cal_req  = 1'b1;
        exp_q.push_back({1'b0, 16'hFFFF, 5'd3});
        tick();
        cal_req = 1'b0;
        tick(); tick();
        taps_drv = '0;
        k = 0;
        while (n_pop < 5 && k < 100) begin tick(); @(negedge clk); k++; end
        n_cmp++;
        if (n_pop !== 5) begin n_bad++; $display("FAIL b2b_pops: got %0d, required 5", n_pop); end
        n_cmp++;
        if (last_pop.cal !== 1'b1 || last_pop.data[TS_W-1:FINE_W] >= 16'h0040) begin
            n_bad++; $display("FAIL b2b_wrap: got last=%h, required calibration with wrapped coarse", last_pop);
        end
        wait_armed("b2b");
        line_en = 1'b0;
    endtask

    task automatic test_abort();
        int k;
        // enable dropped while a timestamp waits in OUT
        ts_ready = 1'b0;
        tick();
        taps_drv = 16'h0003;
        exp_q.push_back({1'b0, mdl_coarse, 5'd2});
        tick(); tick(); @(negedge clk);
        n_cmp++;
        if (ts_valid !== 1'b1) begin n_bad++; $display("FAIL abort_out: got valid=%0b, required 1", ts_valid); end
        tick();
        enable   = 1'b0;
        taps_drv = '0;
        tick(); @(negedge clk);
        n_cmp++;
        if (ts_valid !== 1'b0 || busy !== 1'b0 || cal_sel !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL abort_enable: got valid=%0b busy=%0b sel=%0b drop=%0d, required 0/0/0/%0d",
                     ts_valid, busy, cal_sel, drop_cnt, exp_drop);
        end
        exp_q.delete();
        tick(); tick();
        enable = 1'b1;
        wait_armed("reenable");
        ts_ready = 1'b1;
        tick();
        taps_drv = 16'h0001;
        exp_q.push_back({1'b0, mdl_coarse, 5'd1});
        k = 0;
        while (n_pop < 6 && k < 20) begin tick(); @(negedge clk); k++; end
        n_cmp++;
        if (n_pop !== 6) begin n_bad++; $display("FAIL abort_restart: got pops=%0d, required 6", n_pop); end
        taps_drv = '0;
        wait_armed("restart");

        // asynchronous reset during OUT of a calibration shot
        line_en  = 1'b1;
        ts_ready = 1'b0;
        tick();
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        k = 0;
        do begin tick(); @(negedge clk); k++; end while (ts_valid !== 1'b1 && k < 20);
        n_cmp++;
        if (ts_valid !== 1'b1 || cal_sel !== 1'b1) begin
            n_bad++; $display("FAIL abort_calout: got valid=%0b sel=%0b, required 1/1", ts_valid, cal_sel);
        end
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ts_valid, cal_sel, line_ci, busy, ts_cal} !== 5'b0 || drop_cnt !== 8'd0 || ts_data !== '0) begin
            n_bad++;
            $display("FAIL abort_reset: got valid=%0b sel=%0b ci=%0b busy=%0b drop=%0d data=%h, required all 0",
                     ts_valid, cal_sel, line_ci, busy, drop_cnt, ts_data);
        end
        exp_q.delete();
        exp_drop = 0;
        line_en  = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        wait_armed("postreset");
    endtask

    initial begin
        test_reset();
        test_hit_basic();
        test_backpressure();
        test_cal_shot();
        test_cal_timeout();
        test_back_to_back_wrap();
        test_abort();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdc_delayline_ctrl.md
# tdc_delayline_ctrl

Measurement controller for the CARRY4 tapped delay line TDC. It watches the registered tap vector each cycle, detects a hit, and encodes the thermometer code into a fine value. That fine value is merged with a free-running coarse counter to form a timestamp, which is handed downstream over a valid/ready handshake. The block also owns the line input: it fires self-calibration pulses into CI and enforces dead time until the line has drained.

## Interface
- TAPS, 16: delay-line taps (4 CARRY4 stages × 4).
- COARSE_W, 16: coarse counter width.
- DEAD_CYCLES, 4: minimum cycles in DEAD before re-arm.
- CAL_WIDTH, 8: cycles line_ci is held high for a calibration pulse.
- CAL_TIMEOUT, 8: cycles allowed for a calibration edge to appear.
- FINE_W (derived) = clog2(TAPS+1).
- clk  in  1  100 MHz system clock (ClockGen).
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run control; low forces IDLE.
- cal_req  in  1  single-cycle request for one calibration shot.
- taps  in  TAPS  delay-line CO/O outputs, already double-registered on clk; taps[0] is the first tap.
- cal_sel  out  1  1 = line CI mux takes line_ci, external hit blocked.
- line_ci  out  1  calibration pulse into CI.
- ts_data  out  COARSE_W+FINE_W  {coarse, fine}.
- ts_cal  out  1  timestamp originated from a calibration shot.
- ts_valid  out  1  timestamp available.
- ts_ready  in  1  consumer accepts.
- busy  out  1  state ≠ ARMED and ≠ IDLE.
- cal_err  out  1  one-cycle pulse on calibration timeout.
- drop_cnt  out  8  hits lost while not armed, saturating at 255.

## Operation
- Reset: all outputs 0, state IDLE, coarse = 0, cal_pend = 0.
- edge = taps[0] & ~taps_q[0], where taps_q is the previous sample.
- coarse counts +1 per clk while enable = 1 and wraps modulo 2^COARSE_W. It is held at 0 when enable = 0.
- FSM states:
  - IDLE: enable = 1 and taps == 0 → ARMED.
  - ARMED: on edge → ENCODE, latch coarse and taps, ts_cal = 0. Else if cal_req or cal_pend → CAL, clear cal_pend.
  - CAL: cal_sel = 1; line_ci = 1 for the first CAL_WIDTH cycles. On edge → ENCODE, ts_cal = 1. No edge within CAL_TIMEOUT cycles → DEAD, cal_err pulse, no timestamp.
  - ENCODE: fine = popcount(latched taps), which is bubble tolerant. Load ts_data and set ts_valid → OUT.
  - OUT: hold ts_data until ts_valid & ts_ready, then → DEAD.
  - DEAD: count at least DEAD_CYCLES, then wait for taps == 0 → ARMED. cal_sel and line_ci fall on entry to ARMED.
- Simultaneous edge and cal_req in ARMED: the hit wins and cal_req sets cal_pend.
- cal_req outside ARMED sets cal_pend.
- An edge seen in ENCODE, OUT or DEAD increments drop_cnt (saturating); no timestamp is produced.
- enable = 0 in any state → IDLE next cycle. ts_valid, cal_sel and line_ci clear; drop_cnt is kept.
- Reset mid-operation aborts immediately. Outputs are restored to their reset values asynchronously.

## Timing
- Edge sampled in cycle N gives ENCODE in N+1 and ts_valid = 1 in N+2.
- ts_data is stable while ts_valid = 1 and ts_ready = 0.
- The coarse value captured is the count in cycle N.
- Minimum hit-to-hit period = 2 + 1 (handshake) + DEAD_CYCLES cycles, plus drain time.
- Calibration: line_ci rises the cycle after CAL entry. The edge is expected ≥ 2 cycles later because of tap register latency.
- cal_err and the drop_cnt increment are registered, taking effect 1 cycle after the cause.

## Structure
- Shared header tdc_defs.vh holds:
  - FSM state encodings (IDLE, ARMED, CAL, ENCODE, OUT, DEAD);
  - default TAPS and COARSE_W;
  - the FINE_W clog2 macro.
- Sub-module tdc_therm_popcount: combinational TAPS → FINE_W popcount, reused by the calibration histogrammer.
- The controller contains the FSM, coarse counter, dead/cal counters and the output register.

## Test plan
- Hit with taps[0] rising and taps = 16'h00FF at coarse = 0x0123, ts_ready = 1 → ts_valid 2 cycles later, ts_data = {0x0123, 8}, ts_cal = 0, back in ARMED after DEAD once taps = 0.
- ts_ready held 0 for 10 cycles, then a second edge → ts_data unchanged throughout, drop_cnt = 1.
- cal_req in ARMED with a line model echoing line_ci into taps → cal_sel = 1, line_ci high for 8 cycles, timestamp with ts_cal = 1.
- cal_req with taps stuck at 0 → cal_err pulse after 8 cycles, no ts_valid, return to ARMED.
- Edge and cal_req in the same cycle → hit timestamp first, then calibration timestamp; coarse wrap 0xFFFF → 0x0000 appears correctly in ts_data.
- rst_n or enable deasserted during OUT → ts_valid = 0 and cal_sel = 0 immediately or next cycle respectively; coarse = 0.
